// File: rtl/spi_sram_target.sv
// spi_sram_target: SPI mode-0 target that emulates a 23LC-style serial SRAM
// (READ 0x03 / WRITE 0x02, 16-bit byte address, sequential access) backed by
// on-chip block RAM. SCK, CS_N and MOSI are oversampled in the clk domain;
// nothing is clocked by SCK.
// Optional feature macro: SPI_SRAM_TARGET_MODE_REG_EN adds the mode register
// (RDMR 0x05 / WRMR 0x01; byte, page and sequential modes). Without it the
// target is always sequential and 0x05 / 0x01 are ignored like any unknown
// command.
module spi_sram_target #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          SCK,
  input  logic          CS_N,
  input  logic          MOSI,
  output logic          MISO,
  output logic          busy,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_RD_DATA,
    S_WR_DATA,
    S_IGNORE
  } state_e;

  // Input synchronizers and edge strobes
  logic sck_s1_q, sck_s2_q, sck_d_q;
  logic rise_q, fall_q;
  logic mosi_s1_q, mosi_s2_q, mosi_q;
  logic cs_s1_q, cs_s2_q;
  logic [1:0] cs_vld_q;
  logic armed_q;

  // Protocol state
  state_e state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [14:0]   rx_q, rx_d;
  logic [7:0]    tx_q, tx_d;
  logic [AW-1:0] addr_q, addr_d, addr_nxt;
  logic          is_wr_q, is_wr_d;
  logic          reg_op_q, reg_op_d;
  logic          rose_q, rose_d;
  logic          load_pend_q, load_pend_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;

  // Memory
  logic [7:0]    mem [0:(1<<AW)-1];
  logic [7:0]    rdata_q;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_raddr;

  logic [15:0] rx_shift;
  logic [7:0]  byte_in;
  logic [7:0]  load_src;
  logic        byte_mode;

  assign rx_shift = {rx_q, mosi_q};
  assign byte_in  = rx_shift[7:0];

`ifdef SPI_SRAM_TARGET_MODE_REG_EN
  logic [1:0] mode_q, mode_d;

  assign load_src  = reg_op_q ? {mode_q, 6'b0} : rdata_q;
  assign byte_mode = (mode_q == 2'b00);

  // Next sequential address: page mode wraps within a 32-byte page.
  always_comb begin
    addr_nxt = addr_q + AW'(1);
    if (mode_q == 2'b10) addr_nxt = {addr_q[AW-1:5], addr_q[4:0] + 5'd1};
  end
`else
  assign load_src  = rdata_q;
  assign byte_mode = 1'b0;

  // Next sequential address, wrapping over the whole memory.
  always_comb begin
    addr_nxt = addr_q + AW'(1);
  end
`endif

  // Synchronize the SPI pins and register the SCK edge strobes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      sck_s1_q  <= 1'b0;
      sck_s2_q  <= 1'b0;
      sck_d_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      mosi_q    <= 1'b0;
      // CS chain resets to "deselected" so busy is low in reset; cs_vld_q
      // masks those reset values until the chain carries real pin samples.
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_vld_q  <= 2'b00;
      armed_q   <= 1'b0;
    end else begin
      sck_s1_q  <= SCK;
      sck_s2_q  <= sck_s1_q;
      sck_d_q   <= sck_s2_q;
      rise_q    <= sck_s2_q & ~sck_d_q;
      fall_q    <= ~sck_s2_q & sck_d_q;
      mosi_s1_q <= MOSI;
      mosi_s2_q <= mosi_s1_q;
      mosi_q    <= mosi_s2_q;
      cs_s1_q   <= CS_N;
      cs_s2_q   <= cs_s1_q;
      cs_vld_q  <= {cs_vld_q[0], 1'b1};
      // After reset a transaction may only start once CS_N has been seen high.
      if (cs_s2_q && cs_vld_q[1]) armed_q <= 1'b1;
    end
  end

  // Next-state and datapath decode of the SPI SRAM protocol.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    is_wr_d     = is_wr_q;
    reg_op_d    = reg_op_q;
    rose_d      = rose_q;
    load_pend_d = 1'b0;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_raddr   = addr_nxt;
`ifdef SPI_SRAM_TARGET_MODE_REG_EN
    mode_d      = mode_q;
`endif

    if (cs_s2_q) begin
      // Deselect wins over any SCK edge seen in the same clk; partial bytes are dropped.
      state_d = S_IDLE;
      cnt_d   = '0;
      rose_d  = 1'b0;
    end else begin
      if (load_pend_q) tx_d = load_src;
      case (state_q)
        S_IDLE: begin
          if (armed_q) begin
            state_d  = S_CMD;
            cnt_d    = '0;
            rose_d   = 1'b0;
            reg_op_d = 1'b0;
          end
        end
        S_CMD: begin
          if (rise_q) begin
            rx_d  = rx_shift[14:0];
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d = '0;
              case (byte_in)
                8'h03: begin state_d = S_ADDR; is_wr_d = 1'b0; end
                8'h02: begin state_d = S_ADDR; is_wr_d = 1'b1; end
`ifdef SPI_SRAM_TARGET_MODE_REG_EN
                8'h05: begin
                  state_d     = S_RD_DATA;
                  reg_op_d    = 1'b1;
                  load_pend_d = 1'b1;
                  rose_d      = 1'b0;
                end
                8'h01: begin state_d = S_WR_DATA; reg_op_d = 1'b1; end
`endif
                default: state_d = S_IGNORE;
              endcase
            end
          end
        end
        S_ADDR: begin
          if (rise_q) begin
            rx_d  = rx_shift[14:0];
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd15) begin
              cnt_d  = '0;
              addr_d = rx_shift[AW-1:0];
              if (is_wr_q) begin
                state_d = S_WR_DATA;
              end else begin
                // First byte is read now and loaded into tx on the next clk.
                mem_re      = 1'b1;
                mem_raddr   = rx_shift[AW-1:0];
                load_pend_d = 1'b1;
                rose_d      = 1'b0;
                state_d     = S_RD_DATA;
              end
            end
          end
        end
        S_RD_DATA: begin
          if (rise_q) begin
            rose_d = 1'b1;
            cnt_d  = (cnt_q == 5'd7) ? 5'd0 : cnt_q + 5'd1;
            // Prefetch the following byte on the first rising edge of each byte.
            if (cnt_q == 5'd0 && !reg_op_q) mem_re = 1'b1;
          end else if (fall_q && rose_q) begin
            rose_d = 1'b0;
            if (cnt_q == 5'd0) begin
              if (byte_mode && !reg_op_q) begin
                state_d = S_IGNORE;
              end else begin
                tx_d = load_src;
                if (!reg_op_q) addr_d = addr_nxt;
              end
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end
        S_WR_DATA: begin
          if (rise_q) begin
            rx_d  = rx_shift[14:0];
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d = '0;
              if (reg_op_q) begin
`ifdef SPI_SRAM_TARGET_MODE_REG_EN
                mode_d = byte_in[7:6];
`endif
                state_d = S_IGNORE;
              end else begin
                mem_we      = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = addr_q;
                wr_data_d   = byte_in;
                if (byte_mode) state_d = S_IGNORE;
                else           addr_d  = addr_nxt;
              end
            end
          end
        end
        S_IGNORE: begin
          state_d = S_IGNORE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Protocol state and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      is_wr_q     <= 1'b0;
      reg_op_q    <= 1'b0;
      rose_q      <= 1'b0;
      load_pend_q <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
`ifdef SPI_SRAM_TARGET_MODE_REG_EN
      mode_q      <= 2'b01;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      is_wr_q     <= is_wr_d;
      reg_op_q    <= reg_op_d;
      rose_q      <= rose_d;
      load_pend_q <= load_pend_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
`ifdef SPI_SRAM_TARGET_MODE_REG_EN
      mode_q      <= mode_d;
`endif
    end
  end

  // Block RAM: one write port (data commit) and one registered read port.
  always_ff @(posedge clk) begin
    // NOTE: the RAM and its read register are deliberately not reset so they map onto block RAM.
    if (mem_we) mem[addr_q] <= byte_in;
    if (mem_re) rdata_q <= mem[mem_raddr];
  end

  assign MISO      = (state_q == S_RD_DATA && !load_pend_q) ? tx_q[7] : 1'b0;
  assign busy      = ~cs_s2_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_spi_sram_target.sv
// Self-checking bench for spi_sram_target: drives an SPI mode-0 initiator,
// keeps a reference byte memory, and scores write commits and read bytes
// against expectation queues.
`timescale 1ns/1ps
module tb_spi_sram_target;

  localparam int AW   = 10;
  localparam int HALF = 8;  // SCK half period in clk cycles

  logic          clk = 1'b0;
  logic          reset;
  logic          SCK;
  logic          CS_N;
  logic          MOSI;
  logic          MISO;
  logic          busy;
  logic          wr_strobe;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  always #5 clk = ~clk;

  spi_sram_target #(.AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .SCK       (SCK),
    .CS_N      (CS_N),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]      ref_mem [0:(1<<AW)-1];
  logic [AW+7:0]   exp_wr_q [$];  // {addr, data} of each expected commit
  logic [7:0]      exp_rd_q [$];  // expected read bytes in arrival order
  logic [7:0]      wbuf [$];
  logic [AW+7:0]   mon_exp;
  logic            watch_miso = 1'b0;
  int              miso_hi = 0;
  logic [31:0]     stream;
  logic [7:0]      rx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write-commit monitor and MISO watcher, sampled on the falling clk edge.
  always @(negedge clk) begin
    if (watch_miso && MISO !== 1'b0) miso_hi++;
    if (wr_strobe === 1'b1) begin
      if (exp_wr_q.size() > 0) begin
        mon_exp = exp_wr_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(mon_exp[AW+7:8]));
        check("wr_data", 32'(wr_data), 32'(mon_exp[7:0]));
      end else begin
        check("wr_spurious", 32'(wr_strobe), 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] r);
    r = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      MOSI = tx[i];
      tick(HALF);
      r[i] = MISO;
      SCK = 1'b1;
      tick(HALF);
      SCK = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] r);
    spi_bits(tx, 8, r);
  endtask

  task automatic cs_begin();
    CS_N = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_end();
    tick(HALF);
    CS_N = 1'b1;
    tick(12);
  endtask

  task automatic spi_write(input logic [15:0] addr);
    logic [7:0]    r;
    logic [AW-1:0] a;
    cs_begin();
    spi_byte(8'h02, r);
    spi_byte(addr[15:8], r);
    spi_byte(addr[7:0], r);
    a = addr[AW-1:0];
    foreach (wbuf[k]) begin
      exp_wr_q.push_back({a, wbuf[k]});
      ref_mem[a] = wbuf[k];
      spi_byte(wbuf[k], r);
      a = a + AW'(1);
    end
    cs_end();
  endtask

  task automatic spi_read(input logic [15:0] addr, input int n, output logic [31:0] s);
    logic [7:0]    r;
    logic [AW-1:0] a;
    cs_begin();
    spi_byte(8'h03, r);
    spi_byte(addr[15:8], r);
    spi_byte(addr[7:0], r);
    a = addr[AW-1:0];
    s = '0;
    for (int k = 0; k < n; k++) begin
      exp_rd_q.push_back(ref_mem[a]);
      a = a + AW'(1);
      spi_byte(8'h00, r);
      check("rd_byte", 32'(r), 32'(exp_rd_q.pop_front()));
      s = {s[23:0], r};
    end
    cs_end();
  endtask

  initial begin
    reset = 1'b0;
    SCK   = 1'b0;
    CS_N  = 1'b1;
    MOSI  = 1'b0;
    tick(4);
    check("rst_miso",      32'(MISO),      32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_addr",   32'(wr_addr),   32'd0);
    check("rst_wr_data",   32'(wr_data),   32'd0);
    reset = 1'b1;
    tick(6);

    // Single byte write then read back.
    wbuf = {8'hA5};
    spi_write(16'h0010);
    spi_read(16'h0010, 1, stream);

    // Four-byte sequential write and 32-bit read.
    wbuf = {8'h11, 8'h22, 8'h33, 8'h44};
    spi_write(16'h0100);
    spi_read(16'h0100, 4, stream);
    check("seq_stream", stream, 32'h1122_3344);
    check("seq_swizzled", {stream[7:0], stream[15:8], stream[23:16], stream[31:24]}, 32'h4433_2211);

    // Address wrap at the top of memory.
    wbuf = {8'hDE, 8'hAD};
    spi_write(16'h03FF);
    spi_read(16'h03FF, 2, stream);
    check("wrap_stream", {16'h0, stream[15:0]}, 32'h0000_DEAD);
    spi_read(16'h0000, 1, stream);

    // Abort a write data byte after 5 bits: nothing may be committed.
    wbuf = {8'h5A};
    spi_write(16'h0020);
    cs_begin();
    spi_byte(8'h02, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h20, rx);
    spi_bits(8'hFF, 5, rx);
    cs_end();
    spi_read(16'h0020, 1, stream);

    // Unknown command: MISO stays low, no commit, busy timing around CS_N.
    CS_N = 1'b0;
    tick(1);
    check("busy_rise_1clk", 32'(busy), 32'd0);
    tick(1);
    check("busy_rise_2clk", 32'(busy), 32'd1);
    tick(HALF - 2);
    miso_hi    = 0;
    watch_miso = 1'b1;
    spi_byte(8'h9F, rx);
    spi_byte(8'hFF, rx);
    spi_byte(8'h02, rx);
    spi_byte(8'hAA, rx);
    watch_miso = 1'b0;
    check("ignore_miso_high_samples", 32'(miso_hi), 32'd0);
    tick(HALF);
    CS_N = 1'b1;
    tick(1);
    check("busy_fall_1clk", 32'(busy), 32'd1);
    tick(1);
    check("busy_fall_2clk", 32'(busy), 32'd0);
    tick(12);

    // Reset in the middle of a read.
    cs_begin();
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h10, rx);
    MOSI = 1'b0;
    tick(HALF);
    check("rd_bit7_before_reset", 32'(MISO), 32'd1);
    reset = 1'b0;
    tick(1);
    check("reset_mid_miso", 32'(MISO), 32'd0);
    check("reset_mid_busy", 32'(busy), 32'd0);
    tick(3);
    reset = 1'b1;
    tick(4);
    // CS_N is still low: this write-shaped traffic must be ignored.
    spi_byte(8'h02, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h10, rx);
    spi_byte(8'h77, rx);
    check("post_reset_busy", 32'(busy), 32'd1);
    cs_end();
    spi_read(16'h0100, 4, stream);
    check("post_reset_stream", stream, 32'h1122_3344);
    spi_read(16'h0010, 1, stream);

    tick(20);
    check("wr_pending", 32'(exp_wr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
